// File: rtl/online_sd_pkg.sv
// online_sd_pkg: signed-digit encoding, FSM states and digit helpers for the online adder.
package online_sd_pkg;
  localparam logic [1:0] SD_POS = 2'b10;
  localparam logic [1:0] SD_NEG = 2'b01;
  localparam logic [1:0] SD_ZERO = 2'b00;
  typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;
  function automatic logic signed [1:0] sd_dec(input logic [1:0] d);
    return d == SD_POS ? 2'sd1 : d == SD_NEG ? -2'sd1 : 2'sd0;
  endfunction
  // Subtraction negates y by swapping its {p,n} bits; {1,1} stays zero.
  function automatic logic signed [2:0] sd_sum(input logic [1:0] x, input logic [1:0] y, input logic s);
    return 3'(sd_dec(x)) + 3'(sd_dec(s ? {y[0], y[1]} : y));
  endfunction
  function automatic logic [1:0] sd_enc(input logic signed [2:0] v);
    return v > 0 ? SD_POS : v < 0 ? SD_NEG : SD_ZERO;
  endfunction
endpackage

// File: rtl/online_sd_lane.sv
// online_sd_lane: one digit stream of the online adder; holds p_{j-1}, w_{j-2} and forms s_{j-2}.
module online_sd_lane
  import online_sd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_step,
  input  logic       i_zero,
  input  logic       i_sub,
  input  logic [1:0] i_x,
  input  logic [1:0] i_y,
  output logic [1:0] o_s
);
  logic signed [2:0] r_p, w_p, w_t;
  logic signed [1:0] r_w, w_w;
  always_comb begin
    w_p = i_zero ? 3'sd0 : sd_sum(i_x, i_y, i_sub);
    w_w = (r_p == 3'sd1 || r_p == -3'sd1) ? (w_p[2] ? 2'sd1 : -2'sd1) : 2'sd0;
    w_t = (r_p - 3'(w_w)) >>> 1;
  end
  assign o_s = sd_enc(3'(r_w) + w_t);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_p <= '0;
      r_w <= '0;
    end else if (i_step) begin
      r_p <= w_p;
      r_w <= w_w;
    end
endmodule

// File: rtl/online_addsub_serial.sv
// online_addsub_serial: MSD-first radix-2 signed-digit add/sub, online delay 2, LANES streams.
module online_addsub_serial
  import online_sd_pkg::*;
#(
  parameter int NDIG  = 8,
  parameter int LANES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_vld,
  output logic               in_rdy,
  input  logic               sub,
  input  logic [2*LANES-1:0] x,
  input  logic [2*LANES-1:0] y,
  output logic [2*LANES-1:0] res,
  output logic               out_vld,
  input  logic               out_rdy,
  output logic               out_first,
  output logic               out_last
);
  localparam int CW = $clog2(NDIG + 2);
  state_t r_state;
  logic [CW-1:0] r_cnt;
  logic r_sub, w_free, w_acc, w_step, w_zero, w_lsub;
  logic [2*LANES-1:0] w_s;
  always_comb begin
    w_free = !out_vld || out_rdy;
    in_rdy = rst_n && (r_state == FILL || (r_state == RUN && w_free));
    w_acc  = in_vld && in_rdy;
    w_zero = r_state == FLUSH;
    w_step = w_zero ? w_free : w_acc;
    w_lsub = r_state == FILL ? sub : r_sub;
  end
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    online_sd_lane u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_step (w_step),
      .i_zero (w_zero),
      .i_sub  (w_lsub),
      .i_x    (x[2*i+:2]),
      .i_y    (y[2*i+:2]),
      .o_s    (w_s[2*i+:2])
    );
  end
  // r_cnt is the step index within the frame: 1..NDIG for digits, NDIG+1 for the final flush step.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state   <= FILL;
      r_cnt     <= '0;
      r_sub     <= 1'b0;
      res       <= '0;
      out_vld   <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (w_step && r_state != FILL) begin
        out_vld   <= 1'b1;
        res       <= w_s;
        out_first <= r_cnt == CW'(1);
        out_last  <= r_cnt == CW'(NDIG + 1);
      end else if (out_rdy) out_vld <= 1'b0;
      if (w_step) begin
        r_cnt   <= r_cnt == CW'(NDIG + 1) ? '0 : r_cnt + 1'b1;
        r_state <= r_state == FILL ? RUN :
                   r_state == RUN && r_cnt == CW'(NDIG - 1) ? FLUSH :
                   r_state == FLUSH && r_cnt == CW'(NDIG + 1) ? FILL : r_state;
        if (r_state == FILL) r_sub <= sub;
      end
    end
endmodule

// File: tb/tb_online_addsub_serial.sv
// tb_online_addsub_serial: directed and stalled random frames, checked by digit string and frame value.
module tb_online_addsub_serial;
  localparam int ND = 4;
  localparam int L = 3;
  logic clk, rst_n, in_vld, in_rdy, sub, out_vld, out_rdy, out_first, out_last;
  logic [2*L-1:0] x, y, res;
  int n_chk = 0, n_fail = 0;
  logic [2*L-1:0] fx [0:100][1:ND];
  logic [2*L-1:0] fy [0:100][1:ND];
  logic fsub [0:100];
  logic fdir [0:100];
  logic [2*(ND+1)-1:0] fexp [0:100];

  online_addsub_serial #(.NDIG(ND), .LANES(L)) dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy), .sub(sub), .x(x), .y(y),
    .res(res), .out_vld(out_vld), .out_rdy(out_rdy), .out_first(out_first), .out_last(out_last)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int dv(input logic [1:0] d);
    return d == 2'b10 ? 1 : d == 2'b01 ? -1 : 0;
  endfunction

  function automatic int ev(input int f, input int k);
    int v = 0;
    for (int j = 1; j <= ND; j++)
      v += (dv(fx[f][j][2*k+:2]) + (fsub[f] ? -1 : 1) * dv(fy[f][j][2*k+:2])) * (1 << (ND - j));
    return v;
  endfunction

  task automatic setf(input int f, input logic s, input logic [2*ND-1:0] xs, input logic [2*ND-1:0] ys,
                      input logic [2*(ND+1)-1:0] e);
    for (int j = 1; j <= ND; j++) begin
      fx[f][j] = {L{xs[2*(ND-j)+:2]}};
      fy[f][j] = {L{ys[2*(ND-j)+:2]}};
    end
    fsub[f] = s;
    fdir[f] = 1;
    fexp[f] = e;
  endtask

  task automatic run(input int n, input bit stall);
    int fi = 0, dj = 1, fo = 0, oi = 0, fl = 0, cyc = 0;
    bit infl = 0;
    int gv [L];
    logic [2*(ND+1)-1:0] g0 = '0;
    for (int k = 0; k < L; k++) gv[k] = 0;
    while (fo < n && cyc < 40 * n + 50) begin
      @(negedge clk);
      cyc++;
      in_vld = fi < n;
      x = fi < n ? fx[fi][dj] : '0;
      y = fi < n ? fy[fi][dj] : '0;
      sub = (dj == 1 && fi < n) ? fsub[fi] : 1'($urandom);
      out_rdy = stall ? 1'($urandom) : 1'b1;
      #1;
      if (infl) begin
        chk("flush_in_rdy", in_rdy, 0);
        if (!out_vld || out_rdy) begin
          fl++;
          if (fl == 2) infl = 0;
        end
      end
      if (out_vld && out_rdy) begin
        chk("out_first", out_first, oi == 0);
        chk("out_last", out_last, oi == ND);
        for (int k = 0; k < L; k++) begin
          chk("canonical", res[2*k+:2] == 2'b11, 0);
          gv[k] += dv(res[2*k+:2]) * (1 << (ND - oi));
        end
        g0 = {g0[2*ND-1:0], res[1:0]};
        if (oi == ND) begin
          for (int k = 0; k < L; k++) chk("frame_value", gv[k], ev(fo, k));
          if (fdir[fo]) chk("digits_lane0", int'(g0), int'(fexp[fo]));
          for (int k = 0; k < L; k++) gv[k] = 0;
          fo++;
          oi = 0;
        end else oi++;
      end
      if (in_vld && in_rdy) begin
        if (dj == ND) begin
          dj = 1;
          fi++;
          infl = 1;
          fl = 0;
        end else dj++;
      end
    end
    in_vld = 0;
    out_rdy = 1;
    chk("frames_out", fo, n);
  endtask

  initial begin
    int d;
    rst_n = 0; in_vld = 0; out_rdy = 0; sub = 0; x = '0; y = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_rdy", in_rdy, 0);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_res", res, 0);
    chk("rst_first_last", {out_first, out_last}, 0);
    rst_n = 1;
    setf(0, 0, 8'b10_00_00_00, 8'b10_00_00_00, 10'b10_00_00_00_00);
    setf(1, 0, 8'b10_10_00_00, 8'b00_10_00_00, 10'b10_00_00_00_00);
    setf(2, 1, 8'b10_10_00_00, 8'b00_10_00_00, 10'b10_01_00_00_00);
    setf(3, 0, 8'b01_00_00_10, 8'b00_01_00_00, 10'b01_10_01_10_01);
    setf(4, 1, 8'b10_10_11_01, 8'b10_10_11_01, 10'b00_00_00_00_00);
    run(5, 0);
    // Mid-frame reset after digit 3, then a clean frame.
    d = 1;
    in_vld = 1; out_rdy = 1;
    for (int c = 0; c < 20 && d < 4; c++) begin
      @(negedge clk);
      x = fx[0][d]; y = fy[0][d]; sub = fsub[0];
      #1;
      if (in_rdy) d++;
    end
    chk("pre_rst_digits", d, 4);
    @(negedge clk);
    in_vld = 0;
    #1;
    chk("pre_rst_out_vld", out_vld, 1);
    rst_n = 0;
    #1;
    chk("mid_rst_out_vld", out_vld, 0);
    chk("mid_rst_res", res, 0);
    chk("mid_rst_first_last", {out_first, out_last}, 0);
    chk("mid_rst_in_rdy", in_rdy, 0);
    @(negedge clk);
    rst_n = 1;
    run(1, 0);
    for (int f = 0; f < 100; f++) begin
      for (int j = 1; j <= ND; j++) begin
        fx[f][j] = (2*L)'($urandom);
        fy[f][j] = (2*L)'($urandom);
      end
      fsub[f] = 1'($urandom);
      fdir[f] = 0;
      fexp[f] = '0;
    end
    run(100, 1);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
